execute_cycle: RTL and testbench

- EX stage of the 5-stage MIPS pipeline. Consumes the ID/EX bundle driven by decode_cycle and produces the registered EX/MEM bundle.
- Resolves operand forwarding from MEM and WB, computes the ALU result, and resolves beq/jump (pcsrcE/pctargetE back to fetch; fetch/decode flush on pcsrcE).
- Holds an iterative 32-cycle unsigned divider FSM that stalls the front end through stallE.

---
 rtl/execute_cycle.sv | 223 ++++++++++++++++++++++
 tb/tb_execute_cycle.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/execute_cycle.sv
// EX stage of the 5-stage MIPS pipeline: forwarding, ALU, branch/jump resolution,
// an iterative restoring unsigned divider that stalls the front end, and the EX/MEM register.
module execute_cycle #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             regwriteE,
  input  logic             isimmediateE,
  input  logic             memwriteE,
  input  logic             isloadE,
  input  logic             memreadE,
  input  logic             branchE,
  input  logic             jumpE,
  input  logic [4:0]       alusignalE,
  input  logic [WIDTH-1:0] op1E,
  input  logic [WIDTH-1:0] op2E,
  input  logic [WIDTH-1:0] immxE,
  input  logic [WIDTH-1:0] jumpoffset,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [WIDTH-1:0] pcE,
  input  logic [WIDTH-1:0] pcplus4E,
  input  logic [WIDTH-1:0] aluresultM_in,
  input  logic [4:0]       rdM_in,
  input  logic             regwriteM_in,
  input  logic [WIDTH-1:0] resultW,
  input  logic [4:0]       rdW,
  input  logic             regwriteW,
  output logic             pcsrcE,
  output logic [WIDTH-1:0] pctargetE,
  output logic             stallE,
  output logic             regwriteM,
  output logic             memwriteM,
  output logic             memreadM,
  output logic             isloadM,
  output logic [WIDTH-1:0] aluresultM,
  output logic [WIDTH-1:0] writedataM,
  output logic [WIDTH-1:0] pcplus4M,
  output logic [4:0]       rdM
);

  localparam int unsigned CW = $clog2(DIV_CYCLES);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_SLTU = 5'b01000;
  localparam logic [4:0] ALU_XOR  = 5'b01001;
  localparam logic [4:0] ALU_NOR  = 5'b01010;
  localparam logic [4:0] ALU_LUI  = 5'b01011;
  localparam logic [4:0] ALU_MUL  = 5'b01100;
  localparam logic [4:0] ALU_DIVU = 5'b01110;
  localparam logic [4:0] ALU_REMU = 5'b01111;
  localparam logic [4:0] ALU_SLL  = 5'b10100;
  localparam logic [4:0] ALU_SRL  = 5'b10101;
  localparam logic [4:0] ALU_SRA  = 5'b10110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  div_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_src_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_diff;
  logic [SW-1:0]    w_shamt;
  logic             w_is_shift;
  logic             w_is_div;
  logic             w_stall;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic             w_unused_pc;

  logic             w_regwrite_n;
  logic             w_memwrite_n;
  logic             w_memread_n;
  logic             w_isload_n;
  logic [WIDTH-1:0] w_aluresult_n;
  logic [WIDTH-1:0] w_writedata_n;
  logic [WIDTH-1:0] w_pcplus4_n;
  logic [4:0]       w_rd_n;

  assign w_unused_pc = ^pcE;

  // Operand forwarding: MEM wins over WB, register 0 never forwards.
  always_comb begin
    w_fwd_a = op1E;
    w_fwd_b = op2E;
    if (regwriteM_in && (rdM_in != 5'd0) && (rdM_in == rs1E))
      w_fwd_a = aluresultM_in;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E))
      w_fwd_a = resultW;
    if (regwriteM_in && (rdM_in != 5'd0) && (rdM_in == rs2E))
      w_fwd_b = aluresultM_in;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E))
      w_fwd_b = resultW;
  end

  assign w_is_shift = (alusignalE == ALU_SLL) || (alusignalE == ALU_SRL) || (alusignalE == ALU_SRA);
  assign w_is_div   = (alusignalE == ALU_DIVU) || (alusignalE == ALU_REMU);
  // Shift amount comes straight from the decoded shamt field, never forwarded.
  assign w_src_b    = w_is_shift ? op2E : (isimmediateE ? immxE : w_fwd_b);
  assign w_shamt    = w_src_b[SW-1:0];

  always_comb begin
    w_alu = '0;
    case (alusignalE)
      ALU_AND:  w_alu = w_fwd_a & w_src_b;
      ALU_OR:   w_alu = w_fwd_a | w_src_b;
      ALU_ADD:  w_alu = w_fwd_a + w_src_b;
      ALU_SUB:  w_alu = w_fwd_a - w_src_b;
      ALU_SLT:  w_alu = WIDTH'($signed(w_fwd_a) < $signed(w_src_b));
      ALU_SLTU: w_alu = WIDTH'(w_fwd_a < w_src_b);
      ALU_XOR:  w_alu = w_fwd_a ^ w_src_b;
      ALU_NOR:  w_alu = ~(w_fwd_a | w_src_b);
      ALU_LUI:  w_alu = w_src_b << 16;
      ALU_MUL:  w_alu = w_fwd_a * w_src_b;
      ALU_SLL:  w_alu = w_fwd_a << w_shamt;
      ALU_SRL:  w_alu = w_fwd_a >> w_shamt;
      ALU_SRA:  w_alu = WIDTH'($signed(w_fwd_a) >>> w_shamt);
      default:  w_alu = '0;
    endcase
  end

  assign w_diff    = w_fwd_a - w_src_b;
  assign pcsrcE    = jumpE | (branchE & (w_diff == '0));
  assign pctargetE = jumpE ? jumpoffset : (pcplus4E + (immxE << 2));

  assign w_stall = ((r_state == S_IDLE) && w_is_div) || (r_state == S_BUSY);
  assign stallE  = rst & w_stall;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_trial[WIDTH];

  // EX/MEM next value: bubble while stalled, divider result in DONE.
  always_comb begin
    w_regwrite_n  = 1'b0;
    w_memwrite_n  = 1'b0;
    w_memread_n   = 1'b0;
    w_isload_n    = 1'b0;
    w_aluresult_n = '0;
    w_writedata_n = '0;
    w_pcplus4_n   = '0;
    w_rd_n        = '0;
    if ((r_state == S_DONE) || !w_stall) begin
      w_regwrite_n  = regwriteE;
      w_memwrite_n  = memwriteE;
      w_memread_n   = memreadE;
      w_isload_n    = isloadE;
      w_writedata_n = w_fwd_b;
      w_pcplus4_n   = pcplus4E;
      w_rd_n        = rdE;
      if (r_state == S_DONE)
        w_aluresult_n = (alusignalE == ALU_REMU) ? r_rem : r_quo;
      else
        w_aluresult_n = w_alu;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_dvs      <= '0;
      regwriteM  <= 1'b0;
      memwriteM  <= 1'b0;
      memreadM   <= 1'b0;
      isloadM    <= 1'b0;
      aluresultM <= '0;
      writedataM <= '0;
      pcplus4M   <= '0;
      rdM        <= '0;
    end else begin
      regwriteM  <= w_regwrite_n;
      memwriteM  <= w_memwrite_n;
      memreadM   <= w_memread_n;
      isloadM    <= w_isload_n;
      aluresultM <= w_aluresult_n;
      writedataM <= w_writedata_n;
      pcplus4M   <= w_pcplus4_n;
      rdM        <= w_rd_n;
      case (r_state)
        S_IDLE: begin
          // Operands captured now; WB forwarding data moves on during the stall.
          if (w_is_div) begin
            r_quo   <= w_fwd_a;
            r_dvs   <= w_src_b;
            r_rem   <= '0;
            r_cnt   <= CW'(DIV_CYCLES - 1);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt == '0)
            r_state <= S_DONE;
          else
            r_cnt <= r_cnt - CW'(1);
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed testbench for execute_cycle: reset, forwarding, branch/jump, ALU ops, divider timing and abort.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteE, isimmediateE, memwriteE, isloadE, memreadE, branchE, jumpE;
  logic [4:0]  alusignalE;
  logic [31:0] op1E, op2E, immxE, jumpoffset;
  logic [4:0]  rdE, rs1E, rs2E;
  logic [31:0] pcE, pcplus4E, aluresultM_in;
  logic [4:0]  rdM_in;
  logic        regwriteM_in;
  logic [31:0] resultW;
  logic [4:0]  rdW;
  logic        regwriteW;
  logic        pcsrcE, stallE;
  logic [31:0] pctargetE;
  logic        regwriteM, memwriteM, memreadM, isloadM;
  logic [31:0] aluresultM, writedataM, pcplus4M;
  logic [4:0]  rdM;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .regwriteE(regwriteE), .isimmediateE(isimmediateE), .memwriteE(memwriteE),
    .isloadE(isloadE), .memreadE(memreadE), .branchE(branchE), .jumpE(jumpE),
    .alusignalE(alusignalE), .op1E(op1E), .op2E(op2E), .immxE(immxE),
    .jumpoffset(jumpoffset), .rdE(rdE), .rs1E(rs1E), .rs2E(rs2E),
    .pcE(pcE), .pcplus4E(pcplus4E), .aluresultM_in(aluresultM_in),
    .rdM_in(rdM_in), .regwriteM_in(regwriteM_in), .resultW(resultW),
    .rdW(rdW), .regwriteW(regwriteW), .pcsrcE(pcsrcE), .pctargetE(pctargetE),
    .stallE(stallE), .regwriteM(regwriteM), .memwriteM(memwriteM),
    .memreadM(memreadM), .isloadM(isloadM), .aluresultM(aluresultM),
    .writedataM(writedataM), .pcplus4M(pcplus4M), .rdM(rdM)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    regwriteE = 0; isimmediateE = 0; memwriteE = 0; isloadE = 0; memreadE = 0;
    branchE = 0; jumpE = 0; alusignalE = 5'b00000;
    op1E = 0; op2E = 0; immxE = 0; jumpoffset = 0;
    rdE = 0; rs1E = 0; rs2E = 0; pcE = 0; pcplus4E = 0;
    aluresultM_in = 0; rdM_in = 0; regwriteM_in = 0;
    resultW = 0; rdW = 0; regwriteW = 0;
  endtask

  task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic imm, input logic [31:0] exp);
    set_nop();
    alusignalE = op; op1E = a; op2E = b; immxE = b; isimmediateE = imm;
    regwriteE = 1; rdE = 5'd7;
    step();
    chk(tag, aluresultM, exp);
  endtask

  // Issue a divide, count stalled cycles, confirm bubbles, then check the result.
  task automatic do_div(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int stalls;
    logic bubble_bad;
    set_nop();
    alusignalE = op; op1E = a; op2E = b; regwriteE = 1; rdE = 5'd3; pcplus4E = 32'h44;
    #1;
    stalls = stallE ? 1 : 0;
    bubble_bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!stallE) break;
      stalls++;
      if (regwriteM !== 1'b0 || aluresultM !== 32'h0 || rdM !== 5'd0) bubble_bad = 1;
    end
    chk({tag, "_stalls"}, 32'(stalls), 32'd33);
    chk({tag, "_bubble"}, {31'd0, bubble_bad}, 32'd0);
    step();
    chk({tag, "_result"}, aluresultM, exp);
    chk({tag, "_regwrite"}, {31'd0, regwriteM}, 32'd1);
    chk({tag, "_rd"}, {27'd0, rdM}, 32'd3);
  endtask

  initial begin
    rst = 1'b0;
    set_nop();
    #2;
    chk("rst_alu", aluresultM, 32'h0);
    chk("rst_rw", {31'd0, regwriteM}, 32'd0);
    alusignalE = 5'b00010; op1E = 32'd3; immxE = 32'd4; isimmediateE = 1;
    regwriteE = 1; rdE = 5'd9; pcplus4E = 32'h20;
    #10;
    chk("rst_hold", aluresultM, 32'h0);
    rst = 1'b1;
    step();
    chk("add_res", aluresultM, 32'd7);
    chk("add_rd", {27'd0, rdM}, 32'd9);
    chk("add_pc4", pcplus4M, 32'h20);
    chk("add_nostall", {31'd0, stallE}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_alu", aluresultM, 32'h0);
    chk("rst_async_rw", {31'd0, regwriteM}, 32'd0);
    chk("rst_async_rd", {27'd0, rdM}, 32'd0);
    #1 rst = 1'b1;
    step();
    chk("rst_reload", aluresultM, 32'd7);

    // Forwarding priority
    set_nop();
    alusignalE = 5'b00010; isimmediateE = 1; immxE = 32'd1; op1E = 32'h99; rs1E = 5'd5;
    regwriteM_in = 1; rdM_in = 5'd5; aluresultM_in = 32'h10;
    regwriteW = 1; rdW = 5'd5; resultW = 32'h20; regwriteE = 1; rdE = 5'd1;
    step();
    chk("fwd_mem", aluresultM, 32'h11);
    rdM_in = 5'd0;
    step();
    chk("fwd_wb", aluresultM, 32'h21);
    rs1E = 5'd0;
    step();
    chk("fwd_none", aluresultM, 32'h9A);
    rs2E = 5'd5; op2E = 32'h55;
    step();
    chk("fwd_wdata", writedataM, 32'h20);

    // Branch and jump
    set_nop();
    branchE = 1; alusignalE = 5'b00110; op1E = 32'd7; op2E = 32'd7;
    pcplus4E = 32'h100; immxE = 32'hFFFF_FFFE;
    #1;
    chk("beq_taken", {31'd0, pcsrcE}, 32'd1);
    chk("beq_target", pctargetE, 32'hF8);
    op2E = 32'd8;
    #1;
    chk("beq_not", {31'd0, pcsrcE}, 32'd0);
    branchE = 0; jumpE = 1; jumpoffset = 32'h400;
    #1;
    chk("jump_taken", {31'd0, pcsrcE}, 32'd1);
    chk("jump_target", pctargetE, 32'h400);
    regwriteE = 1; rdE = 5'd31; alusignalE = 5'b00010; op1E = 0; op2E = 0;
    step();
    chk("jump_wb", {31'd0, regwriteM}, 32'd1);

    // ALU ops
    alu_op("sra", 5'b10110, 32'h8000_0000, 32'd4, 0, 32'hF800_0000);
    alu_op("srl", 5'b10101, 32'h8000_0000, 32'd4, 0, 32'h0800_0000);
    alu_op("sll", 5'b10100, 32'h8000_0000, 32'd4, 0, 32'h0);
    alu_op("slt", 5'b00111, 32'hFFFF_FFFF, 32'd1, 0, 32'd1);
    alu_op("sltu", 5'b01000, 32'hFFFF_FFFF, 32'd1, 0, 32'd0);
    alu_op("lui", 5'b01011, 32'h0, 32'h1234, 1, 32'h1234_0000);
    alu_op("mul", 5'b01100, 32'd7, 32'd6, 0, 32'd42);
    alu_op("mul_wrap", 5'b01100, 32'h0001_0001, 32'h0001_0000, 0, 32'h0001_0000);
    alu_op("nor", 5'b01010, 32'h0F0F_0000, 32'h0000_00FF, 0, 32'hF0F0_FF00);
    alu_op("xor", 5'b01001, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 32'hF00F_F00F);
    alu_op("add_wrap", 5'b00010, 32'hFFFF_FFFF, 32'd2, 0, 32'd1);
    alu_op("bad_op", 5'b11111, 32'd5, 32'd5, 0, 32'd0);

    // Divider, back to back
    do_div("divu", 5'b01110, 32'd100, 32'd7, 32'd14);
    do_div("remu", 5'b01111, 32'd100, 32'd7, 32'd2);
    do_div("divu0", 5'b01110, 32'd5, 32'd0, 32'hFFFF_FFFF);
    do_div("remu0", 5'b01111, 32'd5, 32'd0, 32'd5);

    // Abort mid-divide
    set_nop();
    alusignalE = 5'b01110; op1E = 32'd50; op2E = 32'd5; regwriteE = 1; rdE = 5'd3;
    for (int i = 0; i < 11; i++) step();
    chk("abort_busy", {31'd0, stallE}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_stall", {31'd0, stallE}, 32'd0);
    chk("abort_alu", aluresultM, 32'h0);
    #2 rst = 1'b1;
    do_div("after_abort", 5'b01110, 32'd9, 32'd3, 32'd3);

    set_nop();
    step();
    chk("post_nostall", {31'd0, stallE}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
